// File: rtl/mac_result_drain.sv
// mac_result_drain
// Drain stage for a row of MAC accumulators. A start request snapshots all
// N_MAC accumulators, requantizes each one from Q(Q) in W bits to Q(OUT_Q) in
// OUT_W bits with round-half-up and saturation, and pulses mac_clr so the row
// can begin its next tile. The results then stream out one word per
// valid/ready handshake, in index order 0..N_MAC-1.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   start      in   drain request (single-cycle pulse)
//   acc_in     in   N_MAC*W packed accumulators, MAC i at [i*W +: W]
//   mac_clr    out  one-cycle clear pulse to the MAC row
//   busy       out  drain in progress
//   out_valid  out  output word valid
//   out_ready  in   downstream accepts word
//   out_data   out  requantized value
//   out_idx    out  MAC index of out_data
//   out_last   out  high with the word of index N_MAC-1
//   sat        out  sticky saturation flag for the current drain
module mac_result_drain #(
   parameter int N_MAC = 4,
   parameter int W     = 32,
   parameter int Q     = 10,
   parameter int OUT_W = 16,
   parameter int OUT_Q = 8
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [N_MAC*W-1:0]                        acc_in,
   output logic                                      mac_clr,
   output logic                                      busy,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [OUT_W-1:0]                          out_data,
   output logic [((N_MAC > 1) ? $clog2(N_MAC) : 1)-1:0] out_idx,
   output logic                                      out_last,
   output logic                                      sat
);

   localparam int IDX_W  = (N_MAC > 1) ? $clog2(N_MAC) : 1;
   localparam int S      = Q - OUT_Q;
   localparam int SH_RND = (S > 0) ? (S - 1) : 0;

   // Rounding constant: half an output LSB, zero when no shift is needed.
   localparam logic signed [W:0] RND = (S > 0) ? (W+1)'(1 << SH_RND) : (W+1)'(0);

   // Output range, sign-extended to the W+1-bit working width.
   localparam logic signed [W:0] SAT_MAX = {{(W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [W:0] SAT_MIN = {{(W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MAC - 1);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   // Requantize one accumulator. Result bit OUT_W is the saturation flag,
   // bits [OUT_W-1:0] are the clamped output value. The extra bit of working
   // width keeps the rounding add from wrapping at the positive extreme.
   function automatic logic [OUT_W:0] requant(input logic [W-1:0] x);
      logic signed [W:0] v_ext;
      logic signed [W:0] v_r;
      logic [OUT_W:0]    v_res;
      v_ext = signed'({x[W-1], x});
      if (S > 0) begin
         v_r = (v_ext + RND) >>> S;
      end else begin
         v_r = v_ext;
      end
      if (v_r > SAT_MAX) begin
         v_res = {1'b1, SAT_MAX[OUT_W-1:0]};
      end else if (v_r < SAT_MIN) begin
         v_res = {1'b1, SAT_MIN[OUT_W-1:0]};
      end else begin
         v_res = {1'b0, v_r[OUT_W-1:0]};
      end
      return v_res;
   endfunction

   state_t           r_state;
   logic             r_out_valid;
   logic             r_out_last;
   logic             r_mac_clr;
   logic             r_sat;
   logic [OUT_W-1:0] r_out_data;
   logic [IDX_W-1:0] r_idx;
   logic [OUT_W-1:0] r_buf [N_MAC];

   logic [OUT_W:0]   w_req [N_MAC];
   logic             w_sat_any;
   logic             w_hs;
   logic             w_hs_last;
   logic             w_start_acc;
   logic [IDX_W-1:0] w_idx_nxt;

   // Requantize every incoming accumulator and OR their saturation flags.
   always_comb begin
      w_sat_any = 1'b0;
      for (int i = 0; i < N_MAC; i++) begin
         w_req[i]  = requant(acc_in[i*W +: W]);
         w_sat_any = w_sat_any | w_req[i][OUT_W];
      end
   end

   assign w_hs        = r_out_valid & out_ready;
   assign w_hs_last   = w_hs & r_out_last;
   // A start is taken when idle, or exactly on the final handshake so
   // consecutive drains run without a bubble.
   assign w_start_acc = start & ((r_state == S_IDLE) | w_hs_last);
   assign w_idx_nxt   = r_idx + IDX_W'(1);

   // Snapshot buffer; contents are don't-care after reset so it has none.
   always_ff @(posedge clk) begin
      if (w_start_acc) begin
         for (int i = 0; i < N_MAC; i++) begin
            r_buf[i] <= w_req[i][OUT_W-1:0];
         end
      end
   end

   // Control FSM with registered stream outputs and clear pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_mac_clr   <= 1'b0;
         r_sat       <= 1'b0;
         r_out_data  <= '0;
         r_idx       <= '0;
      end else begin
         r_mac_clr <= 1'b0;
         if (w_start_acc) begin
            // Word 0 comes straight from the requantizer since the buffer
            // is being written on this same edge.
            r_state     <= S_STREAM;
            r_out_valid <= 1'b1;
            r_out_last  <= (LAST_IDX == IDX_W'(0));
            r_mac_clr   <= 1'b1;
            r_sat       <= w_sat_any;
            r_out_data  <= w_req[0][OUT_W-1:0];
            r_idx       <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
               end
               S_STREAM: begin
                  if (w_hs) begin
                     if (r_out_last) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_idx       <= '0;
                     end else begin
                        r_idx      <= w_idx_nxt;
                        r_out_data <= r_buf[w_idx_nxt];
                        r_out_last <= (w_idx_nxt == LAST_IDX);
                     end
                  end
               end
               default: begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_idx       <= '0;
               end
            endcase
         end
      end
   end

   assign mac_clr   = r_mac_clr;
   assign busy      = (r_state == S_STREAM);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_idx;
   assign out_last  = r_out_last;
   assign sat       = r_sat;

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain at default parameters.
module tb_mac_result_drain;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int OW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [N*W-1:0]  acc_in;
   logic            mac_clr;
   logic            busy;
   logic            out_valid;
   logic            out_ready;
   logic [OW-1:0]   out_data;
   logic [1:0]      out_idx;
   logic            out_last;
   logic            sat;

   mac_result_drain dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .acc_in    (acc_in),
      .mac_clr   (mac_clr),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  idx;
      logic        last;
   } exp_t;

   typedef struct packed {
      logic [127:0] acc;   // {idx3, idx2, idx1, idx0}
      logic [63:0]  exp;   // {idx3, idx2, idx1, idx0}
      logic         sat;
   } vec_t;

   exp_t sb[$];
   vec_t vecs [5];

   int          hs_count   = 0;
   int          clr_count  = 0;
   logic        prev_clr   = 1'b0;
   logic        prev_stall = 1'b0;
   logic [15:0] pd;
   logic [1:0]  pi;
   logic        pl;
   exp_t        e;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic push_exp(input logic [63:0] ev);
      exp_t t;
      for (int i = 0; i < 4; i++) begin
         t.d    = ev[i*16 +: 16];
         t.idx  = 2'(i);
         t.last = (i == 3);
         sb.push_back(t);
      end
   endtask

   task automatic wait_idle(input int limit, output int cyc);
      cyc = 0;
      while (busy && cyc < limit) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("idle_timeout", busy, 0);
   endtask

   // Output monitor: scoreboard pop on handshake, stall stability, clear pulses.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_clr   = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data",  out_data,  pd);
            check("hold_idx",   out_idx,   pi);
            check("hold_last",  out_last,  pl);
         end
         if (mac_clr) begin
            clr_count++;
            check("mac_clr_single", prev_clr, 0);
         end
         prev_clr = mac_clr;
         if (out_valid && out_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected: got idx %0d data %0h expected no word", out_idx, out_data);
            end else begin
               e = sb.pop_front();
               check("sb_data", out_data, e.d);
               check("sb_idx",  out_idx,  e.idx);
               check("sb_last", out_last, e.last);
            end
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data;
         pi = out_idx;
         pl = out_last;
      end
   end

   task automatic run_vec(input vec_t v);
      int cyc;
      @(posedge clk); #1;
      acc_in    = v.acc;
      start     = 1'b1;
      out_ready = 1'b1;
      push_exp(v.exp);
      @(posedge clk); #1;
      start  = 1'b0;
      acc_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      check("lat_valid", out_valid, 1);
      check("lat_busy",  busy,      1);
      check("lat_clr",   mac_clr,   1);
      check("lat_idx",   out_idx,   0);
      check("lat_data",  out_data,  v.exp[15:0]);
      check("sat_live",  sat,       v.sat);
      wait_idle(100, cyc);
      check("drain_cycles", cyc, 4);
      check("sat_after",    sat, v.sat);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish by 100000");
      $fatal(1, "timeout");
   end

   initial begin
      int          h0;
      int          c0;
      int          cyc;
      logic [7:0]  pat;

      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      acc_in    = '0;
      #1;
      check("rst_busy",  busy,      0);
      check("rst_valid", out_valid, 0);
      check("rst_last",  out_last,  0);
      check("rst_clr",   mac_clr,   0);
      check("rst_sat",   sat,       0);
      check("rst_data",  out_data,  0);
      check("rst_idx",   out_idx,   0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      vecs[0].acc = {32'h00000003, 32'h00000A00, 32'hFFFFFC00, 32'h00000400};
      vecs[0].exp = {16'h0001, 16'h0280, 16'hFF00, 16'h0100};
      vecs[0].sat = 1'b0;
      vecs[1].acc = {32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFD};
      vecs[1].exp = {16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
      vecs[1].sat = 1'b1;
      vecs[2].acc = {32'h00000002, 32'hFFFDFFFE, 32'hFFFE0000, 32'h0001FFFC};
      vecs[2].exp = {16'h0001, 16'h8000, 16'h8000, 16'h7FFF};
      vecs[2].sat = 1'b0;
      vecs[3].acc = {32'hFFFDFFFD, 32'h00000001, 32'hFFFFFFFF, 32'h0001FFFE};
      vecs[3].exp = {16'h8000, 16'h0000, 16'h0000, 16'h7FFF};
      vecs[3].sat = 1'b1;
      vecs[4].acc = {32'h00012345, 32'hFFFFFFF9, 32'h00000006, 32'h00000000};
      vecs[4].exp = {16'h48D1, 16'hFFFE, 16'h0002, 16'h0000};
      vecs[4].sat = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i]);
      end

      // Backpressure: ready pattern 0,0,1,0,1,1,0,1 starting the cycle after start.
      pat = 8'b1011_0100;
      @(posedge clk); #1;
      acc_in    = vecs[0].acc;
      start     = 1'b1;
      out_ready = 1'b0;
      push_exp(vecs[0].exp);
      h0 = hs_count;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         out_ready = pat[k];
         @(posedge clk); #1;
      end
      check("bp_handshakes", hs_count - h0, 4);
      check("bp_busy_done",  busy, 0);
      out_ready = 1'b1;

      // Ignored starts mid-stream, then a start on the final handshake.
      c0 = clr_count;
      @(posedge clk); #1;
      acc_in = vecs[4].acc;
      start  = 1'b1;
      push_exp(vecs[4].exp);
      @(posedge clk); #1;
      start  = 1'b0;
      acc_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      check("ign_idx1", out_idx, 1);
      start = 1'b1;
      @(posedge clk); #1;
      check("ign_idx2", out_idx, 2);
      check("ign_clr2", mac_clr, 0);
      @(posedge clk); #1;
      check("ign_idx3", out_idx, 3);
      check("ign_clr3", mac_clr, 0);
      acc_in = vecs[0].acc;
      push_exp(vecs[0].exp);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy",  busy,      1);
      check("b2b_valid", out_valid, 1);
      check("b2b_idx",   out_idx,   0);
      check("b2b_clr",   mac_clr,   1);
      check("b2b_data",  out_data,  16'h0100);
      wait_idle(100, cyc);
      check("b2b_clr_count", clr_count - c0, 2);

      // Asynchronous reset while stalled at idx 2.
      @(posedge clk); #1;
      acc_in    = vecs[1].acc;
      start     = 1'b1;
      out_ready = 1'b1;
      push_exp(vecs[1].exp);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("rm_idx2", out_idx, 2);
      check("rm_sat",  sat,     1);
      @(posedge clk); #1;
      #1 rst = 1'b1;
      #1;
      check("rm_valid", out_valid, 0);
      check("rm_busy",  busy,      0);
      check("rm_sat0",  sat,       0);
      check("rm_idx0",  out_idx,   0);
      check("rm_last",  out_last,  0);
      check("rm_clr",   mac_clr,   0);
      sb.delete();
      @(posedge clk); #1;
      check("rm_clr_hold", mac_clr, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rm_idle", busy, 0);
      run_vec(vecs[2]);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Drain stage for a row of MAC accumulators. On a start pulse it snapshots `N_MAC` fixed-point accumulator values and pulses a clear back to the MAC row, so the row can begin the next tile while the drain works. It requantizes each value from Q`Q` in `W` bits to Q`OUT_Q` in `OUT_W` bits, with rounding and saturation. It then streams the results out one per transfer on a valid/ready interface.

## Interface
- `N_MAC`, 4, number of accumulators drained per start (≥2)
- `W`, 32, accumulator width, signed
- `Q`, 10, fractional bits of accumulator input
- `OUT_W`, 16, output width, signed
- `OUT_Q`, 8, fractional bits of output; requires `Q ≥ OUT_Q`; shift `S = Q − OUT_Q`
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  drain request, single-cycle pulse
- `acc_in`  in  N_MAC*W  accumulator values; MAC i occupies bits [i*W +: W]
- `mac_clr`  out  1  one-cycle clear pulse to the MAC row
- `busy`  out  1  drain in progress
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  downstream accepts word
- `out_data`  out  OUT_W  requantized value
- `out_idx`  out  clog2(N_MAC)  MAC index of `out_data`
- `out_last`  out  1  high with the word where `out_idx == N_MAC−1`
- `sat`  out  1  sticky: at least one value of the current drain saturated

## Operation
- States: IDLE and STREAM.
- Start acceptance:
  - In IDLE, `start` is accepted.
  - In STREAM, `start` is accepted only in the cycle of the final handshake (`out_valid & out_ready & out_last`).
  - Otherwise `start` is ignored. It is not queued.
- Capture on an accepted start, at that clock edge:
  - Every `acc_in` slice is requantized and stored in an internal `N_MAC`×`OUT_W` buffer.
  - Per-entry saturation flags are ORed into `sat`; `sat` is reloaded, not accumulated across drains.
  - `out_idx` ← 0.
  - State ← STREAM.
  - `mac_clr` ← 1 for exactly one cycle.
- Requantization, per value `x`:
  - If `S > 0`: `r = (x + 2^(S−1)) >>> S`, computed in W+1 bits so it cannot wrap. This is round-half-up toward +∞.
  - If `S = 0`: `r = x`.
  - If `r > 2^(OUT_W−1)−1`, output the max and flag saturation.
  - If `r < −2^(OUT_W−1)`, output the min and flag saturation.
- STREAM:
  - `out_valid = 1`, `out_data = buffer[out_idx]`, `out_last = (out_idx == N_MAC−1)`.
  - On each handshake, `out_idx` increments.
  - After the handshake with `out_last`, state returns to IDLE, unless a simultaneous start is accepted.
- `out_valid` never depends combinationally on `out_ready`.
- While `out_valid & !out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
- `acc_in` is ignored outside the capture edge.
- `busy = (state == STREAM)`.

## Timing
- Reset values:
  - `busy`, `out_valid`, `out_last`, `mac_clr`, `sat`: 0
  - `out_data`, `out_idx`: 0
  - State: IDLE
  - Buffer contents: don't-care
- Latency: a start sampled at edge E0 gives `out_valid`, `busy` and `mac_clr` high in the cycle after E0, with `out_idx = 0`.
- Throughput: with `out_ready` held high, `N_MAC` words arrive on consecutive cycles. `busy` drops the cycle after the last handshake.
- Back-to-back drains: a start accepted on the final handshake edge recaptures the buffer. The next cycle presents idx 0 of the new drain with no bubble, and `mac_clr` pulses again.
- Reset mid-stream: all outputs return to reset values immediately (asynchronous). The drain is abandoned, and no `mac_clr` is issued.
- `mac_clr` is never high for two consecutive cycles unless two starts are accepted on consecutive edges. That case is possible only when `N_MAC` = 1, which is excluded by `N_MAC ≥ 2`.

## Test plan
- Basic drain (defaults, `out_ready = 1`):
  - Stimulus: `acc_in` = {0x00000003, 0x00000A00, 0xFFFFFC00, 0x00000400} for idx 3..0, then start.
  - Response: `out_data` 0x0100, 0xFF00, 0x0280, 0x0001 at idx 0..3 on four consecutive cycles starting one cycle after start.
  - `out_last` only on idx 3; `mac_clr` a single pulse; `sat` = 0; `busy` low the cycle after idx 3.
- Saturation and rounding:
  - Stimulus: `acc_in` = {0x7FFFFFFF, 0x80000000, 0xFFFFFFFE, 0xFFFFFFFD}.
  - Response: 0x7FFF, 0x8000, 0x0000, 0xFFFF; `sat` = 1.
  - A following clean drain returns `sat` to 0.
- Backpressure:
  - Stimulus: `out_ready` pattern 0,0,1,0,1,1,0,1.
  - Response: `out_data`/`out_idx` stable while stalled; exactly four handshakes in order 0..3; no duplicated or dropped index.
- Start handling:
  - Start pulses during idx 1 and idx 2 are ignored: no `mac_clr`, stream unaffected.
  - Start coincident with the idx 3 handshake, with new `acc_in`: idx 0 of the new data appears the next cycle; a second `mac_clr` pulse; `busy` stays high.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously while at idx 2 with `out_ready` = 0.
  - Response: `out_valid`/`busy`/`sat` drop to 0 without waiting for an edge.
  - After release, a new start drains fresh data from idx 0.
